// File: rtl/nn_wb_driver.sv
// Host-side initiator for the NN register block: writes opA/opB, pulses the start strobe,
// waits out the fixed NN pipeline latency and returns the sampled result on a valid/ready port.
module nn_wb_driver #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          VALID_CYCLES = 2,
  parameter int          NN_LATENCY   = 70,
  parameter int          ACK_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_op_a,
  input  logic [31:0] cmd_op_b,
  input  logic [2:0]  cmd_round_mode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] wbs_adr_i,
  output logic [31:0] wbs_dat_i,
  output logic        wren,
  input  logic        wbs_ack_o,
  output logic [2:0]  round_mode,
  output logic        in_valid_user,
  input  logic [31:0] NN_result
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_A, S_GAP, S_WR_B, S_FIRE, S_WAIT, S_RESP
  } state_t;

  localparam logic [9:0] ACK_LAST   = 10'(ACK_TIMEOUT - 1);
  localparam logic [9:0] VALID_LAST = 10'(VALID_CYCLES - 1);
  localparam logic [9:0] LAT_LAST   = 10'(NN_LATENCY - 1);

  state_t      state;
  logic [9:0]  cnt;
  logic [31:0] op_b;

  // rst_l is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_l) begin
      state         <= S_IDLE;
      cnt           <= '0;
      op_b          <= '0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_data      <= '0;
      wbs_adr_i     <= '0;
      wbs_dat_i     <= '0;
      wren          <= 1'b0;
      round_mode    <= '0;
      in_valid_user <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_b       <= cmd_op_b;
            round_mode <= cmd_round_mode;
            cmd_ready  <= 1'b0;
            wbs_adr_i  <= BASE_ADDR;
            wbs_dat_i  <= cmd_op_a;
            wren       <= 1'b1;
            cnt        <= '0;
            state      <= S_WR_A;
          end
        end

        S_WR_A, S_WR_B: begin
          if (wbs_ack_o) begin
            wren <= 1'b0;
            cnt  <= '0;
            if (state == S_WR_A) begin
              state <= S_GAP;
            end else begin
              in_valid_user <= 1'b1;
              state         <= S_FIRE;
            end
          end else if (cnt == ACK_LAST) begin
            // Abort: the NN never saw a start pulse, so report an error with no data.
            wren      <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end

        S_GAP: begin
          wbs_adr_i <= BASE_ADDR + 32'd4;
          wbs_dat_i <= op_b;
          wren      <= 1'b1;
          cnt       <= '0;
          state     <= S_WR_B;
        end

        S_FIRE: begin
          if (cnt == VALID_LAST) begin
            in_valid_user <= 1'b0;
            cnt           <= '0;
            state         <= S_WAIT;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end

        S_WAIT: begin
          if (cnt == LAT_LAST) begin
            rsp_data  <= NN_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            cnt       <= '0;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
